// File: rtl/tg_pkg.sv
// tg_pkg: shared types for the tg traffic sinks.
// Backpressure modes, FSM states, config bundle, LFSR step.
package tg_pkg;

  typedef enum logic [1:0] {
    BP_ALWAYS = 2'd0,
    BP_DUTY   = 2'd1,
    BP_LFSR   = 2'd2
  } bp_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Run configuration, captured on the start cycle.
  typedef struct packed {
    logic [1:0]  bp_mode;
    logic [15:0] num_packets;
    logic [15:0] num_flits;
    logic [7:0]  lfb;
    logic [15:0] m;
    logic [15:0] n;
  } cfg_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/tg_checker_if.sv
// tg_checker_if: AXI-Stream beat bundle.
// master = traffic source, slave = sink.
interface tg_checker_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0]   TDATA;
  logic [WIDTH/8-1:0] TKEEP;
  logic               TVALID;
  logic               TREADY;
  logic               TLAST;

  modport master (
    output TDATA,
    output TKEEP,
    output TVALID,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TKEEP,
    input  TVALID,
    input  TLAST,
    output TREADY
  );

endinterface

// File: rtl/tg_bp_gen.sv
// tg_bp_gen: backpressure pattern source.
// ready_next is the TREADY value for the next cycle.
module tg_bp_gen
  import tg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        step,
  input  logic [1:0]  mode,
  input  logic [15:0] m,
  input  logic [15:0] n,
  output logic        ready_next
);

  logic [16:0] phase_q;
  logic [16:0] phase_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [16:0] m_eff;
  logic [16:0] period;
  logic [16:0] phase_inc;

  assign m_eff     = (m == 16'd0) ? 17'd1 : {1'b0, m};
  assign period    = m_eff + {1'b0, n};
  assign phase_inc = phase_q + 17'd1;

  // Phase and LFSR restart together so each run sees the same pattern.
  always_comb begin
    phase_d = phase_q;
    lfsr_d  = lfsr_q;
    if (restart) begin
      phase_d = '0;
      lfsr_d  = LFSR_SEED;
    end else if (step) begin
      phase_d = (phase_inc >= period) ? 17'd0 : phase_inc;
      lfsr_d  = lfsr_step(lfsr_q);
    end
  end

  // Pattern value for the cycle that phase_d / lfsr_d describe.
  always_comb begin
    ready_next = 1'b1;
    case (mode)
      BP_DUTY: ready_next = (n == 16'd0) | (phase_d < m_eff);
      BP_LFSR: ready_next = lfsr_d[0];
      default: ready_next = 1'b1;
    endcase
  end

  // Pattern state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
    end
  end

endmodule

// File: rtl/tg_checker.sv
// tg_checker: AXI-Stream sink for the tg generator.
// Backpressure, framing checks, counters, checksum.
module tg_checker
  import tg_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       bp_mode,
  input  logic [15:0]      num_packets,
  input  logic [15:0]      num_flits,
  input  logic [7:0]       last_flit_bytes,
  input  logic [15:0]      M,
  input  logic [15:0]      N,
  tg_checker_if.slave      axis,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] flit_cnt,
  output logic [CNT_W-1:0] run_cycles,
  output logic [WIDTH-1:0] checksum,
  output logic             err_last_early,
  output logic             err_last_missing,
  output logic             err_keep,
  output logic             done
);

  localparam int BYTES = WIDTH / 8;

  state_e            state_q;
  state_e            state_d;
  cfg_t              cfg_q;
  cfg_t              cfg_d;
  logic [15:0]       fidx_q;
  logic [15:0]       fidx_d;
  logic [CNT_W-1:0]  pkt_q;
  logic [CNT_W-1:0]  pkt_d;
  logic [CNT_W-1:0]  flit_q;
  logic [CNT_W-1:0]  flit_d;
  logic [CNT_W-1:0]  run_q;
  logic [CNT_W-1:0]  run_d;
  logic [WIDTH-1:0]  csum_q;
  logic [WIDTH-1:0]  csum_d;
  logic              early_q;
  logic              early_d;
  logic              miss_q;
  logic              miss_d;
  logic              keep_q;
  logic              keep_d;
  logic              done_q;
  logic              done_d;
  logic              tready_q;
  logic              tready_d;

  logic              running;
  logic              start_ok;
  logic              beat;
  logic              final_beat;
  logic              bp_ready;
  logic [15:0]       nf_eff;
  logic [15:0]       last_idx;
  logic [BYTES-1:0]  lfb_mask;
  logic [BYTES-1:0]  exp_keep;
  logic [CNT_W-1:0]  pkt_inc;

  // Byte mask of the last flit; 0 or oversize means a full flit.
  function automatic logic [BYTES-1:0] mask_of(input logic [7:0] lfb);
    logic [BYTES-1:0] mk;
    mk = '0;
    for (int i = 0; i < BYTES; i++) begin
      mk[i] = (lfb == 8'd0) || (int'(lfb) > BYTES) || (i < int'(lfb));
    end
    return mk;
  endfunction

  assign running    = (state_q == S_RUN);
  assign start_ok   = start & ~running;
  assign beat       = running & tready_q & axis.TVALID;
  assign nf_eff     = (cfg_q.num_flits == 16'd0) ? 16'd1 : cfg_q.num_flits;
  assign last_idx   = nf_eff - 16'd1;
  assign lfb_mask   = mask_of(cfg_q.lfb);
  assign exp_keep   = (fidx_q == last_idx) ? lfb_mask : '1;
  assign pkt_inc    = pkt_q + CNT_W'(1);
  assign final_beat = beat & axis.TLAST
                    & (cfg_q.num_packets != 16'd0)
                    & (pkt_inc == CNT_W'(cfg_q.num_packets));

  tg_bp_gen u_bp (
    .clk        (clk),
    .rst        (rst),
    .restart    (start_ok),
    .step       (running),
    .mode       (cfg_d.bp_mode),
    .m          (cfg_d.m),
    .n          (cfg_d.n),
    .ready_next (bp_ready)
  );

  // Run-state next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (final_beat) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Config capture, framing checks, counters and checksum.
  always_comb begin
    cfg_d   = cfg_q;
    fidx_d  = fidx_q;
    pkt_d   = pkt_q;
    flit_d  = flit_q;
    run_d   = run_q;
    csum_d  = csum_q;
    early_d = early_q;
    miss_d  = miss_q;
    keep_d  = keep_q;
    done_d  = done_q;
    if (start_ok) begin
      cfg_d.bp_mode     = bp_mode;
      cfg_d.num_packets = num_packets;
      cfg_d.num_flits   = num_flits;
      cfg_d.lfb         = last_flit_bytes;
      cfg_d.m           = M;
      cfg_d.n           = N;
      fidx_d  = '0;
      pkt_d   = '0;
      flit_d  = '0;
      run_d   = '0;
      csum_d  = '0;
      early_d = 1'b0;
      miss_d  = 1'b0;
      keep_d  = 1'b0;
      done_d  = 1'b0;
    end else if (running) begin
      run_d = run_q + CNT_W'(1);
      if (beat) begin
        flit_d = flit_q + CNT_W'(1);
        csum_d = csum_q ^ axis.TDATA;
        if (axis.TKEEP != exp_keep) keep_d = 1'b1;
        if (axis.TLAST) begin
          pkt_d  = pkt_inc;
          fidx_d = '0;
          if (fidx_q < last_idx) early_d = 1'b1;
        end else begin
          if (fidx_q == last_idx) miss_d = 1'b1;
          if (fidx_q != 16'hFFFF) fidx_d = fidx_q + 16'd1;
        end
        if (final_beat) done_d = 1'b1;
      end
    end
  end

  // TREADY only follows the pattern while the next cycle is a RUN cycle.
  always_comb begin
    tready_d = 1'b0;
    if (state_d == S_RUN) tready_d = bp_ready;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      fidx_q   <= '0;
      pkt_q    <= '0;
      flit_q   <= '0;
      run_q    <= '0;
      csum_q   <= '0;
      early_q  <= 1'b0;
      miss_q   <= 1'b0;
      keep_q   <= 1'b0;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      fidx_q   <= fidx_d;
      pkt_q    <= pkt_d;
      flit_q   <= flit_d;
      run_q    <= run_d;
      csum_q   <= csum_d;
      early_q  <= early_d;
      miss_q   <= miss_d;
      keep_q   <= keep_d;
      done_q   <= done_d;
      tready_q <= tready_d;
    end
  end

  assign axis.TREADY      = tready_q;
  assign pkt_cnt          = pkt_q;
  assign flit_cnt         = flit_q;
  assign run_cycles       = run_q;
  assign checksum         = csum_q;
  assign err_last_early   = early_q;
  assign err_last_missing = miss_q;
  assign err_keep         = keep_q;
  assign done             = done_q;

endmodule

// File: tb/tb_tg_checker.sv
// tb_tg_checker: randomized stream bench for tg_checker.
// Behavioural model compared every cycle, plus literal pins.
module tb_tg_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  bp_mode;
  logic [15:0] num_packets;
  logic [15:0] num_flits;
  logic [7:0]  last_flit_bytes;
  logic [15:0] M;
  logic [15:0] N;
  logic [31:0] pkt_cnt;
  logic [31:0] flit_cnt;
  logic [31:0] run_cycles;
  logic [63:0] checksum;
  logic        err_last_early;
  logic        err_last_missing;
  logic        err_keep;
  logic        done;

  tg_checker_if #(.WIDTH(64)) axis ();

  tg_checker #(.WIDTH(64), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .bp_mode          (bp_mode),
    .num_packets      (num_packets),
    .num_flits        (num_flits),
    .last_flit_bytes  (last_flit_bytes),
    .M                (M),
    .N                (N),
    .axis             (axis),
    .pkt_cnt          (pkt_cnt),
    .flit_cnt         (flit_cnt),
    .run_cycles       (run_cycles),
    .checksum         (checksum),
    .err_last_early   (err_last_early),
    .err_last_missing (err_last_missing),
    .err_keep         (err_keep),
    .done             (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;
  int          m_mode, m_np, m_nf, m_lfb, m_m, m_n;
  int          m_k, m_fidx;
  bit [15:0]   m_lfsr;
  bit          m_ready, m_early, m_miss, m_keep, m_done;
  bit [31:0]   m_pkt, m_flit, m_run;
  bit [63:0]   m_csum;

  function automatic bit pattern();
    int mm;
    if (m_mode == 1) begin
      mm = (m_m == 0) ? 1 : m_m;
      if (m_n == 0) return 1'b1;
      return (m_k % (mm + m_n)) < mm;
    end
    if (m_mode == 2) return m_lfsr[0];
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int nf;
    int lastpos;
    bit [7:0] ek;
    bit fin;
    bit fb;
    if (!rst) begin
      m_state = 0; m_ready = 0; m_early = 0; m_miss = 0;
      m_keep = 0; m_done = 0; m_pkt = 0; m_flit = 0;
      m_run = 0; m_csum = 0; m_fidx = 0;
      m_mode = 0; m_np = 0; m_nf = 0; m_lfb = 0; m_m = 0; m_n = 0;
    end else if (m_state != 1) begin
      if (start) begin
        m_mode = bp_mode; m_np = num_packets; m_nf = num_flits;
        m_lfb = last_flit_bytes; m_m = M; m_n = N;
        m_pkt = 0; m_flit = 0; m_run = 0; m_csum = 0; m_fidx = 0;
        m_early = 0; m_miss = 0; m_keep = 0; m_done = 0;
        m_state = 1; m_k = 0; m_lfsr = 16'hACE1;
        m_ready = pattern();
      end
    end else begin
      fin = 0;
      m_run++;
      if (m_ready && axis.TVALID) begin
        nf = (m_nf == 0) ? 1 : m_nf;
        lastpos = nf - 1;
        ek = 8'hFF;
        if (m_fidx == lastpos && m_lfb != 0 && m_lfb < 8)
          ek = 8'((1 << m_lfb) - 1);
        m_flit++;
        m_csum ^= axis.TDATA;
        if (axis.TKEEP != ek) m_keep = 1;
        if (axis.TLAST) begin
          if (m_fidx < lastpos) m_early = 1;
          m_fidx = 0;
          m_pkt++;
          if (m_np != 0 && m_pkt == 32'(m_np)) fin = 1;
        end else begin
          if (m_fidx == lastpos) m_miss = 1;
          if (m_fidx != 65535) m_fidx++;
        end
      end
      if (fin) begin
        m_state = 2; m_done = 1; m_ready = 0;
      end else begin
        m_k++;
        fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
        m_ready = pattern();
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("TREADY", 64'(axis.TREADY), 64'(m_ready));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      chk("flit_cnt", 64'(flit_cnt), 64'(m_flit));
      chk("run_cycles", 64'(run_cycles), 64'(m_run));
      chk("checksum", checksum, m_csum);
      chk("err_last_early", 64'(err_last_early), 64'(m_early));
      chk("err_last_missing", 64'(err_last_missing), 64'(m_miss));
      chk("err_keep", 64'(err_keep), 64'(m_keep));
      chk("done", 64'(done), 64'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t q[$];
  bit    rdy_trace[$];

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void add_pkt(input int nbeats, input logic [7:0] lastkeep);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.d = rnd64();
      b.k = (i == nbeats - 1) ? lastkeep : 8'hFF;
      b.l = (i == nbeats - 1);
      q.push_back(b);
    end
  endfunction

  task automatic do_start(input int mode, input int np, input int nf,
                          input int lfb, input int m, input int n);
    bp_mode = 2'(mode); num_packets = 16'(np); num_flits = 16'(nf);
    last_flit_bytes = 8'(lfb); M = 16'(m); N = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bp_mode = 2'($urandom); num_packets = 16'($urandom);
    num_flits = 16'($urandom); last_flit_bytes = 8'($urandom);
    M = 16'($urandom); N = 16'($urandom);
  endtask

  task automatic send(input bit gaps);
    int cyc;
    bit pend;
    bit rdy;
    cyc = 0;
    pend = 0;
    while (q.size() > 0) begin
      if (!pend && gaps && $urandom_range(0, 3) == 0) begin
        axis.TVALID = 1'b0;
        @(negedge clk);
      end else begin
        axis.TVALID = 1'b1;
        axis.TDATA = q[0].d;
        axis.TKEEP = q[0].k;
        axis.TLAST = q[0].l;
        rdy = axis.TREADY;
        rdy_trace.push_back(rdy);
        @(negedge clk);
        if (rdy) begin
          q.delete(0);
          pend = 0;
        end else begin
          pend = 1;
        end
      end
      cyc++;
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d beats left expected 0", q.size());
        q.delete();
      end
    end
    axis.TVALID = 1'b0;
    axis.TLAST = 1'b0;
  endtask

  int          lfb_t[4] = '{3, 3, 0, 9};
  logic [7:0]  kp_t[4]  = '{8'h0F, 8'h07, 8'hFF, 8'hFF};
  logic        ek_t[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [10:0] tv;
    logic [3:0]  lv;
    logic [63:0] x7;
    logic [63:0] cur;
    int          bi;
    bit          rdy;

    rst = 1'b0; start = 1'b0; bp_mode = 0; num_packets = 0;
    num_flits = 0; last_flit_bytes = 0; M = 0; N = 0;
    axis.TVALID = 1'b0; axis.TDATA = '0; axis.TKEEP = '0; axis.TLAST = 1'b0;

    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_tready", 64'(axis.TREADY), 64'd0);
    chk("rst_counts", {pkt_cnt, flit_cnt}, 64'd0);
    chk("rst_flags", 64'({err_last_early, err_last_missing, err_keep, done}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, three clean 4-flit packets
    do_start(0, 3, 4, 8, 1, 0);
    repeat (3) add_pkt(4, 8'hFF);
    send(1);
    chk("t1_pkt", 64'(pkt_cnt), 64'd3);
    chk("t1_flit", 64'(flit_cnt), 64'd12);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_errs", 64'({err_last_early, err_last_missing, err_keep}), 64'd0);
    repeat (3) @(negedge clk);
    chk("t1_tready_after", 64'(axis.TREADY), 64'd0);

    // mode 1 duty 2 on / 3 off, one 5-flit packet
    do_start(1, 1, 5, 8, 2, 3);
    add_pkt(5, 8'hFF);
    rdy_trace.delete();
    send(0);
    tv = '0;
    for (int i = 0; i < 11; i++)
      if (i < rdy_trace.size()) tv = {tv[9:0], rdy_trace[i]};
    chk("t2_pattern", 64'(tv), 64'b11000110001);
    chk("t2_trace_len", 64'(rdy_trace.size()), 64'd11);
    chk("t2_run_cycles", 64'(run_cycles), 64'd11);
    chk("t2_flit", 64'(flit_cnt), 64'd5);

    // early TLAST then a clean packet
    do_start(0, 2, 4, 8, 1, 0);
    add_pkt(2, 8'hFF);
    send(1);
    chk("t3_pkt1", 64'(pkt_cnt), 64'd1);
    chk("t3_early", 64'(err_last_early), 64'd1);
    add_pkt(4, 8'hFF);
    send(1);
    chk("t3_pkt2", 64'(pkt_cnt), 64'd2);
    chk("t3_other", 64'({err_last_missing, err_keep}), 64'd0);

    // TKEEP on the last flit
    for (int i = 0; i < 4; i++) begin
      do_start(0, 1, 2, lfb_t[i], 1, 0);
      add_pkt(2, kp_t[i]);
      send(1);
      chk($sformatf("t4_keep%0d", i), 64'(err_keep), 64'(ek_t[i]));
    end

    // missing TLAST, extra beats
    do_start(0, 1, 3, 8, 1, 0);
    add_pkt(5, 8'hFF);
    send(1);
    chk("t5_missing", 64'(err_last_missing), 64'd1);
    chk("t5_early", 64'(err_last_early), 64'd0);
    chk("t5_flit", 64'(flit_cnt), 64'd5);

    // num_flits = 0 acts as 1, lfb = 2
    do_start(0, 2, 0, 2, 1, 0);
    add_pkt(1, 8'h03);
    add_pkt(1, 8'h03);
    send(1);
    chk("t5b_pkt", 64'(pkt_cnt), 64'd2);
    chk("t5b_errs", 64'({err_last_early, err_last_missing, err_keep}), 64'd0);

    // reset in the middle of a run
    do_start(0, 0, 8, 8, 1, 0);
    add_pkt(8, 8'hFF);
    repeat (3) q.delete(q.size() - 1);
    send(0);
    chk("t6_flit", 64'(flit_cnt), 64'd5);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_counts", {pkt_cnt, flit_cnt}, 64'd0);
    chk("t6_run_sum", {run_cycles, 32'd0} | checksum, 64'd0);
    chk("t6_bits", 64'({axis.TREADY, done, err_last_early, err_last_missing, err_keep}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    do_start(0, 1, 2, 8, 1, 0);
    chk("t6_restart_flit", 64'(flit_cnt), 64'd0);
    add_pkt(2, 8'hFF);
    send(1);
    chk("t6_after", {pkt_cnt, flit_cnt}, {32'd1, 32'd2});

    // mode 2 LFSR, unbounded, 1000 cycles of TVALID
    do_start(2, 0, 4, 8, 1, 0);
    x7 = '0;
    bi = 0;
    cur = rnd64();
    lv = '0;
    for (int c = 0; c < 1000; c++) begin
      axis.TVALID = 1'b1;
      axis.TDATA = cur;
      axis.TKEEP = 8'hFF;
      axis.TLAST = (bi % 4 == 3);
      rdy = axis.TREADY;
      if (c < 4) lv = {lv[2:0], rdy};
      @(negedge clk);
      if (rdy) begin
        x7 ^= cur;
        bi++;
        cur = rnd64();
      end
    end
    axis.TVALID = 1'b0;
    axis.TLAST = 1'b0;
    chk("t7_lfsr_first4", 64'(lv), 64'b1000);
    chk("t7_checksum", checksum, x7);
    chk("t7_flit", 64'(flit_cnt), 64'(bi));
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_errs", 64'({err_last_early, err_last_missing, err_keep}), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
